// File: rtl/regfile_debug_access.sv
// Debug-side initiator for the integer register file: halts the core, performs
// read / write / dump-all accesses on the RF ports, and streams back responses.
module regfile_debug_access #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [AW-1:0]   rsp_addr,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_last,
  output logic            rsp_err,
  output logic            halt_req,
  input  logic            halt_ack,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [2:0]      dbg_state
);

  // Handshakes: a beat transfers on any rising edge where valid && ready are
  // both high; the sender holds its payload stable while valid && !ready.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_ACCESS    = 3'd2,
    S_RSP       = 3'd3,
    S_RELEASE   = 3'd4
  } state_e;

  localparam logic [1:0]    OP_READ  = 2'b00;
  localparam logic [1:0]    OP_WRITE = 2'b01;
  localparam logic [1:0]    OP_DUMP  = 2'b10;
  localparam logic [1:0]    OP_RSVD  = 2'b11;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            halt_req_q, halt_req_d;
  logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_last_q, rsp_last_d;
  logic            rsp_err_q, rsp_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      halt_req_q <= 1'b0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      halt_req_q <= halt_req_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    halt_req_d = halt_req_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rf_raddr   = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          cnt_d   = '0;
          if (cmd_op == OP_RSVD) begin
            // Reserved op answers immediately without disturbing the core.
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            rsp_addr_d = cmd_addr;
            rsp_last_d = 1'b1;
            state_d    = S_RSP;
          end else begin
            rsp_err_d  = 1'b0;
            halt_req_d = 1'b1;
            state_d    = S_HALT_WAIT;
          end
        end
      end

      S_HALT_WAIT: begin
        if (halt_ack) state_d = S_ACCESS;
      end

      S_ACCESS: begin
        rsp_err_d = 1'b0;
        state_d   = S_RSP;
        case (op_q)
          OP_READ: begin
            rf_raddr   = addr_q;
            rsp_data_d = rf_rdata;
            rsp_addr_d = addr_q;
            rsp_last_d = 1'b1;
          end
          OP_WRITE: begin
            rf_waddr   = addr_q;
            rf_wdata   = wdata_q;
            // x0 is hardwired to zero, so the write is suppressed and echoed as 0.
            rf_we      = (addr_q != '0) && halt_ack;
            rsp_data_d = (addr_q == '0) ? '0 : wdata_q;
            rsp_addr_d = addr_q;
            rsp_last_d = 1'b1;
          end
          default: begin
            rf_raddr   = cnt_q;
            rsp_data_d = rf_rdata;
            rsp_addr_d = cnt_q;
            rsp_last_d = (cnt_q == LAST_IDX);
          end
        endcase
      end

      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          if (op_q == OP_DUMP && cnt_q != LAST_IDX) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_ACCESS;
          end else if (op_q == OP_RSVD) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RELEASE;
          end
        end
      end

      S_RELEASE: begin
        halt_req_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign halt_req  = halt_req_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_debug_access.sv
// Directed bench for regfile_debug_access: behavioural register file model,
// driver tasks for the command/response channels, and a dump scoreboard.
module tb_regfile_debug_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        halt_req;
  logic        halt_ack;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  dbg_state;

  regfile_debug_access #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register file model plus write/halt monitors
  logic [31:0] rf [32];
  int          preload_mode = 0;
  int          we_count = 0;
  int          we_bad = 0;
  int          halt_cycles = 0;
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (halt_req) halt_cycles <= halt_cycles + 1;
    if (preload_mode != 0) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i * 32'h11);
      if (preload_mode == 1) rf[5] <= 32'h1234_5678;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
      we_count     <= we_count + 1;
      last_waddr   <= rf_waddr;
      last_wdata   <= rf_wdata;
      if (!halt_ack) we_bad <= we_bad + 1;
    end
  end

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] r_data;
  logic [4:0]  r_addr;
  logic        r_last;
  logic        r_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic preload(input int mode);
    @(negedge clk);
    preload_mode = mode;
    @(negedge clk);
    preload_mode = 0;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    chk("cmd_ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp();
    bit got = 0;
    r_data = '0; r_addr = '0; r_last = 1'b0; r_err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        r_data = rsp_data; r_addr = rsp_addr; r_last = rsp_last; r_err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        got = 1;
        break;
      end
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int w0, h0, beat, holds, stab_bad, bad;
    logic [31:0] hd;
    logic [4:0]  ha;
    bit prev_hold, seen;

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; halt_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_halt_req", {31'b0, halt_req}, 32'd0);
    chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("rst_state", {29'b0, dbg_state}, 32'd0);
    rst = 1'b1;
    preload(1);

    // read x5 with halt_ack already high: exact latency
    drive_cmd(2'b00, 5'd5, 32'h0);
    @(negedge clk);
    chk("rd_halt_req_up", {31'b0, halt_req}, 32'd1);
    chk("rd_valid_e1", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_valid_e2", {31'b0, rsp_valid}, 32'd0);
    chk("rd_raddr", {27'b0, rf_raddr}, 32'd5);
    @(negedge clk);
    chk("rd_valid_e3", {31'b0, rsp_valid}, 32'd1);
    chk("rd_data", rsp_data, 32'h1234_5678);
    chk("rd_addr", {27'b0, rsp_addr}, 32'd5);
    chk("rd_last", {31'b0, rsp_last}, 32'd1);
    chk("rd_err", {31'b0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("rd_release_halt", {31'b0, halt_req}, 32'd1);
    chk("rd_release_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_halt_dropped", {31'b0, halt_req}, 32'd0);
    chk("rd_idle_ready", {31'b0, cmd_ready}, 32'd1);

    // write x10, then read it back
    w0 = we_count;
    drive_cmd(2'b01, 5'd10, 32'hCAFE_BABE);
    get_rsp();
    chk("wr_rsp_data", r_data, 32'hCAFE_BABE);
    chk("wr_rsp_addr", {27'b0, r_addr}, 32'd10);
    chk("wr_rsp_last", {31'b0, r_last}, 32'd1);
    wait_idle();
    chk("wr_we_pulses", 32'(we_count - w0), 32'd1);
    chk("wr_waddr", {27'b0, last_waddr}, 32'd10);
    chk("wr_wdata", last_wdata, 32'hCAFE_BABE);
    drive_cmd(2'b00, 5'd10, 32'h0);
    get_rsp();
    chk("wr_readback", r_data, 32'hCAFE_BABE);
    wait_idle();

    // x0 write is suppressed
    w0 = we_count;
    drive_cmd(2'b01, 5'd0, 32'hFFFF_FFFF);
    get_rsp();
    chk("x0_rsp_data", r_data, 32'h0);
    chk("x0_rsp_addr", {27'b0, r_addr}, 32'd0);
    wait_idle();
    chk("x0_no_we", 32'(we_count - w0), 32'd0);

    // dump with rsp_ready pattern 1-0-0-1
    preload(2);
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 32'h11));
    drive_cmd(2'b10, 5'd0, 32'h0);
    beat = 0; holds = 0; stab_bad = 0; prev_hold = 0; hd = '0; ha = '0;
    for (int cyc = 0; cyc < 2000 && beat < 32; cyc++) begin
      @(negedge clk);
      rsp_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (rsp_valid) begin
        if (prev_hold && (rsp_data !== hd || rsp_addr !== ha)) stab_bad++;
        if (rsp_ready) begin
          chk("dump_addr", {27'b0, rsp_addr}, 32'(beat));
          chk("dump_data", rsp_data, exp_q.pop_front());
          chk("dump_last", {31'b0, rsp_last}, {31'b0, beat == 31});
          beat++;
          prev_hold = 0;
        end else begin
          holds++;
          prev_hold = 1;
          hd = rsp_data;
          ha = rsp_addr;
        end
      end else begin
        prev_hold = 0;
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("dump_beats", 32'(beat), 32'd32);
    chk("dump_stable", 32'(stab_bad), 32'd0);
    chk("dump_backpressured", {31'b0, holds > 0}, 32'd1);
    wait_idle();

    // halt_ack held low for 10 cycles after halt_req rises
    @(negedge clk);
    halt_ack = 1'b0;
    w0 = we_count;
    drive_cmd(2'b01, 5'd3, 32'hA5A5_A5A5);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (halt_req) begin seen = 1; break; end
    end
    chk("hw_halt_req_up", {31'b0, seen}, 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || rf_we) bad++;
    end
    chk("hw_quiet_wait", 32'(bad), 32'd0);
    chk("hw_no_we_wait", 32'(we_count - w0), 32'd0);
    halt_ack = 1'b1;
    @(negedge clk);
    chk("hw_we_access", {31'b0, rf_we}, 32'd1);
    chk("hw_waddr", {27'b0, rf_waddr}, 32'd3);
    chk("hw_wdata", rf_wdata, 32'hA5A5_A5A5);
    get_rsp();
    chk("hw_rsp_data", r_data, 32'hA5A5_A5A5);
    wait_idle();
    chk("hw_we_pulses", 32'(we_count - w0), 32'd1);

    // reset asserted while dump beat 7 is pending
    drive_cmd(2'b10, 5'd0, 32'h0);
    beat = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rsp_valid && beat == 7) break;
      rsp_ready = 1'b1;
      if (rsp_valid) beat++;
    end
    rsp_ready = 1'b0;
    chk("mid_dump_beat", 32'(beat), 32'd7);
    chk("mid_dump_addr", {27'b0, rsp_addr}, 32'd7);
    rst = 1'b0;
    #1;
    chk("mid_rst_halt_req", {31'b0, halt_req}, 32'd0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("mid_rst_state", {29'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // reserved op
    h0 = halt_cycles;
    drive_cmd(2'b11, 5'd9, 32'h1234);
    get_rsp();
    chk("rsv_err", {31'b0, r_err}, 32'd1);
    chk("rsv_data", r_data, 32'h0);
    chk("rsv_addr", {27'b0, r_addr}, 32'd9);
    chk("rsv_last", {31'b0, r_last}, 32'd1);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("rsv_no_halt", 32'(halt_cycles - h0), 32'd0);
    chk("we_only_when_halted", 32'(we_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
